rr_mux: RTL
===========

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel in bits.
REQ-002 Parameter NCH, default 4: number of input channels, legal range 2..8.
REQ-003 Parameter SW, default 2: select width, shall equal ceil(log2(NCH)).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 d  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 vld_in  input  NCH  per-channel valid.
REQ-008 rdy_out  output  NCH  per-channel ready; one-hot or zero.
REQ-009 mode  input  1  0 = explicit select via s; 1 = round-robin arbitration.
REQ-010 s  input  SW  channel select, used only when mode=0.
REQ-011 y  output  WIDTH  registered output data.
REQ-012 y_ch  output  SW  index of the channel that produced y.
REQ-013 y_vld  output  1  y/y_ch hold a valid beat.
REQ-014 y_rdy  input  1  downstream accepts the beat when y_vld=1 and y_rdy=1.
REQ-015 xfer_cnt  output  16  count of accepted input beats (see Configuration).

Function
REQ-016 Output stage load enable: ld = (!y_vld) | y_rdy; combinational, no bubble on back-to-back traffic.
REQ-017 mode=0: grant channel s iff s < NCH and vld_in[s]=1; otherwise no grant.
REQ-018 mode=1: grant the first channel with vld_in=1, searching ptr, ptr+1, ... modulo NCH.
REQ-019 rdy_out[g] = ld for the granted channel g; all other rdy_out bits = 0; rdy_out = 0 when there is no grant.
REQ-020 Accept = grant & ld; on accept, y<=d[g], y_ch<=g, y_vld<=1 at the next edge (latency 1 cycle).
REQ-021 ld=1 with no grant: y_vld<=0; y and y_ch hold their previous values.
REQ-022 y_vld=1 and y_rdy=0: y, y_vld and y_ch shall hold stable; rdy_out=0.
REQ-023 Simultaneous output consume and new accept in one cycle: the new beat replaces the old one; no loss, no duplicate.
REQ-024 On accept in mode=1: ptr <= (g+1) mod NCH, wrapping from NCH-1 to 0.
REQ-025 In mode=0, ptr shall not change.
REQ-026 mode and s may change on any cycle; they take effect for the same-cycle grant decision.
REQ-027 Fairness: with all channels valid and y_rdy=1, mode=1 grants 0,1,...,NCH-1,0,... with one grant per cycle.

Reset
REQ-028 When reset=1: y=0, y_ch=0, y_vld=0, ptr=0 and xfer_cnt=0 at the next edge.
REQ-029 rdy_out = 0 while reset=1.
REQ-030 Reset asserted mid-stream shall drop any pending output beat with no partial state retained.

Configuration
REQ-031 Macro RR_MUX_CNT_EN defined: xfer_cnt increments by 1 on every accept and wraps from 16'hFFFF to 0.
REQ-032 RR_MUX_CNT_EN undefined: xfer_cnt is tied to 0, no counter logic exists, and the port remains present.

Verification
REQ-033 mode=0, s=1, d={AF,AD,43,33}, vld_in=4'hF, y_rdy=1 -> one cycle later y=8'h43, y_ch=1, y_vld=1.
REQ-034 mode=1, vld_in=4'hF, y_rdy=1 for 6 cycles after reset -> y_ch sequence 0,1,2,3,0,1.
REQ-035 mode=1, vld_in=4'b1010, y_rdy=1 -> y_ch alternates 1,3,1,3; rdy_out[0] and rdy_out[2] are never 1.
REQ-036 y_vld=1, y_rdy=0 for 3 cycles -> y, y_ch stable and rdy_out=0 throughout; y_rdy=1 -> next beat on the following edge.
REQ-037 Reset pulse while y_vld=1 -> y_vld=0, y=0, ptr=0; the next mode=1 grant starts at channel 0.
REQ-038 With RR_MUX_CNT_EN defined, preload via 65537 accepts -> xfer_cnt=1; with the macro undefined -> xfer_cnt=0 always.

Source files
------------

// File: rtl/rr_mux.sv
// Registered N:1 multiplexer with explicit select or round-robin arbitration and a ready/valid output stage.
// Define RR_MUX_CNT_EN to enable the 16-bit accepted-beat counter on xfer_cnt; otherwise xfer_cnt is tied to zero.
module rr_mux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SW    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*WIDTH-1:0]   d,
  input  logic [NCH-1:0]         vld_in,
  output logic [NCH-1:0]         rdy_out,
  input  logic                   mode,
  input  logic [SW-1:0]          s,
  output logic [WIDTH-1:0]       y,
  output logic [SW-1:0]          y_ch,
  output logic                   y_vld,
  input  logic                   y_rdy,
  output logic [15:0]            xfer_cnt
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [SW-1:0]    y_ch_q, y_ch_d;
  logic             y_vld_q, y_vld_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic             ld;
  logic             gnt_any;
  logic [SW-1:0]    gnt_idx;
  logic [SW-1:0]    cand;
  logic             accept;

  assign ld     = !y_vld_q || y_rdy;
  assign accept = gnt_any && ld;

  // Round-robin scans from the highest offset down so the channel nearest ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!mode) begin
      if (int'(s) < NCH) begin
        gnt_any = vld_in[s];
        gnt_idx = s;
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        cand = SW'((int'(ptr_q) + k) % NCH);
        if (vld_in[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    rdy_out = '0;
    if (!reset && accept) begin
      rdy_out[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    y_d     = y_q;
    y_ch_d  = y_ch_q;
    y_vld_d = y_vld_q;
    ptr_d   = ptr_q;
    if (ld) begin
      y_vld_d = accept;
      if (accept) begin
        y_d    = d[int'(gnt_idx)*WIDTH +: WIDTH];
        y_ch_d = gnt_idx;
      end
    end
    if (accept && mode) begin
      ptr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q     <= '0;
      y_ch_q  <= '0;
      y_vld_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      y_q     <= y_d;
      y_ch_q  <= y_ch_d;
      y_vld_q <= y_vld_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y     = y_q;
  assign y_ch  = y_ch_q;
  assign y_vld = y_vld_q;

`ifdef RR_MUX_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule
